power_ctrl: RTL and testbench
=============================

// Module: power_ctrl
// PURPOSE
//   Engine power controller upstream of SimulatedDevice: produces next_power and power_light.
//   Debounces the raw power_on/power_off buttons, applies a long-press power-on and immediate power-off.
//   Forces power-off on a manual-mode stall (manual_power=0) and on reserved global_state 2'b11.
// PARAMETERS
//   DEBOUNCE_CYCLES  2_000_000      cycles a raw button level must hold before it is accepted (20 ms @100 MHz)
//   HOLD_CYCLES      100_000_000    cycles debounced power_on must stay high in ARMING to reach ON (1 s)
//   BLINK_CYCLES     25_000_000     power_light toggle period while in ARMING
//   IDLE_CYCLES      1_000_000_000  ON-state inactivity limit (used only with POWER_IDLE_TIMEOUT_EN)
// PORTS
//   sys_clk       in   1  system clock, 100 MHz
//   rst           in   1  asynchronous reset, active-low
//   global_state  in   2  mode: 00 manual, 01/10 semi/auto, 11 reserved
//   power_on      in   1  raw power-on button, asynchronous to sys_clk
//   power_off     in   1  raw power-off button, asynchronous to sys_clk
//   manual_power  in   1  from the manual unit; 0 = stall, honoured only when global_state==00
//   activity      in   1  1 = any drive or turn input active this cycle (idle-timeout restart)
//   next_power    out  1  1 = engine powered
//   power_light   out  1  power indicator LED
// BEHAVIOUR
//   Reset (rst=0, async):
//     FSM=OFF; all counters, synchronisers and debounced levels = 0.
//     next_power=0, power_light=0.
//   Input path:
//     Each button passes a 2-FF synchroniser, then a debouncer.
//     The debounce counter clears whenever the synced level equals the stable level.
//     The stable level flips on the edge after DEBOUNCE_CYCLES consecutive mismatching cycles.
//     Debounced outputs: pon_db, poff_db.
//   FSM states: OFF, ARMING, ON, LOCKOUT. Transitions are registered; outputs decode from the state register.
//   OFF:
//     pon_db=1 and poff_db=0 -> ARMING, hold_cnt=0.
//     pon_db and poff_db both 1 -> stay OFF.
//   ARMING:
//     hold_cnt increments each cycle.
//     poff_db=1 or pon_db=0 -> OFF.
//     hold_cnt==HOLD_CYCLES-1 with pon_db=1 -> ON.
//   ON exit priority, every exit goes to LOCKOUT:
//     1) poff_db=1
//     2) global_state==00 and manual_power=0
//     3) idle timeout
//   LOCKOUT:
//     Stay until pon_db=0 and poff_db=0, then -> OFF.
//     Purpose: a still-held button cannot re-arm immediately.
//   Reserved mode: global_state==11 in any state except OFF -> LOCKOUT.
//     While global_state==11, OFF does not advance.
//   Outputs:
//     next_power = (state==ON).
//     power_light: OFF/LOCKOUT 0; ON 1.
//     ARMING: starts at 1 and toggles every BLINK_CYCLES (blink_cnt wraps to 0 at BLINK_CYCLES-1).
//   Latency:
//     Raw power_on rise to next_power=1 is exactly 2+DEBOUNCE_CYCLES+1+HOLD_CYCLES cycles, if held throughout.
//     Raw power_off rise to next_power=0 is 2+DEBOUNCE_CYCLES+1 cycles.
//   Counter widths: $clog2(param) bits, compare-and-clear only, never free-running wrap.
//   A stall or reserved mode on the same cycle as the ARMING->ON compare takes priority: -> LOCKOUT, not ON.
// CONFIGURATION
//   POWER_IDLE_TIMEOUT_EN defined:
//     idle_cnt clears on entry to ON and on any cycle with activity=1.
//     idle_cnt==IDLE_CYCLES-1 in ON -> LOCKOUT.
//   POWER_IDLE_TIMEOUT_EN undefined:
//     No idle counter; activity is ignored; the port remains.
// STRUCTURE
//   Package power_pkg:
//     State encoding localparams (OFF=2'd0, ARMING=2'd1, ON=2'd2, LOCKOUT=2'd3).
//     Mode constants (MODE_MANUAL=2'b00, MODE_RSVD=2'b11).
//     Default cycle constants.
//   Sub-module btn_debounce (synchroniser + debounce counter, DEBOUNCE_CYCLES parameter).
//     Instantiated twice, once per button.
//   FSM, hold/blink/idle counters live in power_ctrl.
// TESTING  (bench params: DEBOUNCE=4, HOLD=16, BLINK=4, IDLE=32)
//   1) Hold power_on from cycle 0 -> next_power=1 at cycle 23; power_light blinks 1,0,1,.. every 4 cycles in ARMING.
//   2) power_on held 10 cycles then released -> FSM returns to OFF; next_power stays 0.
//   3) In ON, pulse power_off for 2 cycles (glitch) -> no change.
//      Hold power_off 6 cycles -> next_power=0 at raw+7.
//      FSM stays in LOCKOUT until power_off is released and debounced.
//   4) ON, global_state=00, manual_power=0 -> LOCKOUT, next_power=0 in 1 cycle.
//      Same with global_state=01 -> stays ON.
//   5) ON, global_state->11 -> LOCKOUT.
//      rst=0 asserted mid-ARMING -> next_power=0 and power_light=0 immediately.
//      After rst release, the FSM is in OFF.
//   6) With POWER_IDLE_TIMEOUT_EN: ON, activity=0 for 32 cycles -> LOCKOUT.
//      An activity pulse at cycle 20 restarts the count.
//      Without the macro: stays ON indefinitely.

Source files
------------

// File: rtl/power_pkg.sv
// Shared definitions for the engine power controller.
// Contents: state encoding, mode constants, default cycle counts and a helper that
// sizes compare-and-clear counters.
package power_pkg;

   localparam logic [1:0] ST_OFF     = 2'd0;
   localparam logic [1:0] ST_ARMING  = 2'd1;
   localparam logic [1:0] ST_ON      = 2'd2;
   localparam logic [1:0] ST_LOCKOUT = 2'd3;

   typedef enum logic [1:0] {
      StOff     = ST_OFF,
      StArming  = ST_ARMING,
      StOn      = ST_ON,
      StLockout = ST_LOCKOUT
   } power_state_e;

   localparam logic [1:0] MODE_MANUAL = 2'b00;
   localparam logic [1:0] MODE_RSVD   = 2'b11;

   localparam int unsigned DEF_DEBOUNCE_CYCLES = 2_000_000;
   localparam int unsigned DEF_HOLD_CYCLES     = 100_000_000;
   localparam int unsigned DEF_BLINK_CYCLES    = 25_000_000;
   localparam int unsigned DEF_IDLE_CYCLES     = 1_000_000_000;

   // Counter width for a limit of n cycles; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/power_ctrl_if.sv
// Control/status bundle between the mode logic, the buttons and power_ctrl.
// Signals: global_state (mode), power_on/power_off (raw buttons), manual_power (0 = stall),
// activity (drive/turn input active), next_power (engine powered), power_light (LED).
// master: the side driving mode and button inputs; slave: power_ctrl.
interface power_ctrl_if;

   logic [1:0] global_state;
   logic       power_on;
   logic       power_off;
   logic       manual_power;
   logic       activity;
   logic       next_power;
   logic       power_light;

   modport master (
      output global_state, power_on, power_off, manual_power, activity,
      input  next_power, power_light
   );

   modport slave (
      input  global_state, power_on, power_off, manual_power, activity,
      output next_power, power_light
   );

endinterface

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchroniser followed by a debounce counter.
// Ports: sys_clk (clock), rst (async active-low reset), btn_raw (asynchronous button level),
//        btn_db (debounced level).
// The stable level flips on the edge after DEBOUNCE_CYCLES consecutive cycles in which the
// synchronised level disagrees with it; any agreeing cycle clears the counter.
module btn_debounce
   import power_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic sys_clk,
   input  logic rst,
   input  logic btn_raw,
   output logic btn_db
);

   localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q;
   logic          sync2_q;
   logic          stable_q;
   logic [CW-1:0] cnt_q;

   always_ff @(posedge sys_clk or negedge rst) begin
      if (!rst) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
         if (sync2_q == stable_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_LAST) begin
            stable_q <= sync2_q;
            cnt_q    <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign btn_db = stable_q;

endmodule

// File: rtl/power_ctrl.sv
// Engine power controller: long-press power-on, immediate power-off, forced power-off on a
// manual-mode stall or reserved mode, lockout until both buttons are released.
// Ports: sys_clk (clock), rst (async active-low reset), bus (power_ctrl_if.slave: mode,
//        raw buttons, manual_power, activity in; next_power, power_light out).
// Optional feature: define POWER_IDLE_TIMEOUT_EN to drop to LOCKOUT after IDLE_CYCLES in ON
// without activity. Without it, activity is ignored.
module power_ctrl
   import power_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
   parameter int unsigned BLINK_CYCLES    = DEF_BLINK_CYCLES,
   parameter int unsigned IDLE_CYCLES     = DEF_IDLE_CYCLES
) (
   input logic         sys_clk,
   input logic         rst,
   power_ctrl_if.slave bus
);

   localparam int unsigned HW = cnt_width(HOLD_CYCLES);
   localparam int unsigned BW = cnt_width(BLINK_CYCLES);
   localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

   logic pon_db;
   logic poff_db;

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_pon_db (
      .sys_clk (sys_clk),
      .rst     (rst),
      .btn_raw (bus.power_on),
      .btn_db  (pon_db)
   );

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_poff_db (
      .sys_clk (sys_clk),
      .rst     (rst),
      .btn_raw (bus.power_off),
      .btn_db  (poff_db)
   );

   power_state_e  state_q, state_d;
   logic [HW-1:0] hold_cnt_q, hold_cnt_d;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic          blink_q, blink_d;

   logic reserved;
   logic stall;
   logic hold_done;
   logic idle_done;

   assign reserved  = (bus.global_state == MODE_RSVD);
   assign stall     = (bus.global_state == MODE_MANUAL) && !bus.manual_power;
   assign hold_done = (hold_cnt_q == HOLD_LAST);

`ifdef POWER_IDLE_TIMEOUT_EN
   localparam int unsigned IW = cnt_width(IDLE_CYCLES);
   localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);

   logic [IW-1:0] idle_cnt_q, idle_cnt_d;

   assign idle_done = (state_q == StOn) && (idle_cnt_q == IDLE_LAST);

   // Held at zero outside ON, so entering ON always starts a fresh count.
   always_comb begin
      idle_cnt_d = idle_cnt_q;
      if (bus.activity || (state_q != StOn)) begin
         idle_cnt_d = '0;
      end else if (!idle_done) begin
         idle_cnt_d = idle_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge sys_clk or negedge rst) begin
      if (!rst) begin
         idle_cnt_q <= '0;
      end else begin
         idle_cnt_q <= idle_cnt_d;
      end
   end
`else
   logic unused_activity;
   assign unused_activity = bus.activity;
   assign idle_done       = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      hold_cnt_d  = hold_cnt_q;
      blink_cnt_d = blink_cnt_q;
      blink_d     = blink_q;

      unique case (state_q)
         StOff: begin
            // Reserved mode freezes OFF; pressing both buttons is treated as no request.
            if (!reserved && pon_db && !poff_db) begin
               state_d     = StArming;
               hold_cnt_d  = '0;
               blink_cnt_d = '0;
               blink_d     = 1'b1;
            end
         end

         StArming: begin
            if (!hold_done) begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
            if (blink_cnt_q == BLINK_LAST) begin
               blink_cnt_d = '0;
               blink_d     = ~blink_q;
            end else begin
               blink_cnt_d = blink_cnt_q + 1'b1;
            end

            if (reserved) begin
               state_d = StLockout;
            end else if (poff_db || !pon_db) begin
               state_d = StOff;
            end else if (hold_done) begin
               // A stall at the moment of power-up wins over turning on.
               state_d = stall ? StLockout : StOn;
            end
         end

         StOn: begin
            if (reserved || poff_db || stall || idle_done) begin
               state_d = StLockout;
            end
         end

         StLockout: begin
            if (!reserved && !pon_db && !poff_db) begin
               state_d = StOff;
            end
         end

         default: begin
            state_d = StOff;
         end
      endcase
   end

   always_ff @(posedge sys_clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StOff;
         hold_cnt_q  <= '0;
         blink_cnt_q <= '0;
         blink_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_cnt_q  <= hold_cnt_d;
         blink_cnt_q <= blink_cnt_d;
         blink_q     <= blink_d;
      end
   end

   always_comb begin
      bus.next_power  = (state_q == StOn);
      bus.power_light = (state_q == StOn) || ((state_q == StArming) && blink_q);
   end

endmodule

// File: tb/tb_power_ctrl.sv
// Directed self-checking bench for power_ctrl with DEBOUNCE=4, HOLD=16, BLINK=4, IDLE=32.
module tb_power_ctrl;
   import power_pkg::*;

   logic sys_clk;
   logic rst;
   int   n_total;
   int   n_pass;

   power_ctrl_if bus ();

   power_ctrl #(
      .DEBOUNCE_CYCLES (4),
      .HOLD_CYCLES     (16),
      .BLINK_CYCLES    (4),
      .IDLE_CYCLES     (32)
   ) dut (
      .sys_clk (sys_clk),
      .rst     (rst),
      .bus     (bus)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge sys_clk);
         #1;
      end
   endtask

   task automatic test_reset();
      #3;
      if (bus.next_power !== 1'b0 || bus.power_light !== 1'b0) begin
         $display("FAIL reset_outputs got np=%b light=%b exp 0 0", bus.next_power,
                  bus.power_light);
      end else n_pass++;
      n_total++;
      if (dut.state_q !== StOff) begin
         $display("FAIL reset_state got %0d exp %0d", dut.state_q, StOff);
      end else n_pass++;
      n_total++;
      tick(1);
      rst = 1'b1;
      tick(2);
      if (bus.next_power !== 1'b0 || dut.state_q !== StOff) begin
         $display("FAIL post_reset got np=%b state=%0d exp 0 %0d", bus.next_power, dut.state_q,
                  StOff);
      end else n_pass++;
      n_total++;
   endtask

   // Raw press at edge 0: ARMING from edge 7, light 1/0 every 4 cycles, ON at edge 23.
   task automatic test_long_press();
      logic exp_np;
      logic exp_light;
      bus.power_on = 1'b1;
      for (int k = 1; k <= 23; k++) begin
         tick(1);
         exp_np    = (k == 23);
         exp_light = (k >= 7 && k <= 10) || (k >= 15 && k <= 18) || (k == 23);
         if (bus.next_power !== exp_np) begin
            $display("FAIL long_press_np k=%0d got %b exp %b", k, bus.next_power, exp_np);
         end else n_pass++;
         n_total++;
         if (bus.power_light !== exp_light) begin
            $display("FAIL long_press_light k=%0d got %b exp %b", k, bus.power_light, exp_light);
         end else n_pass++;
         n_total++;
      end
      bus.power_on = 1'b0;
      tick(10);
      if (bus.next_power !== 1'b1) begin
         $display("FAIL release_in_on got np=%b exp 1", bus.next_power);
      end else n_pass++;
      n_total++;
   endtask

   task automatic test_power_off();
      bus.power_off = 1'b1;
      tick(2);
      bus.power_off = 1'b0;
      tick(10);
      if (bus.next_power !== 1'b1) begin
         $display("FAIL off_glitch got np=%b exp 1", bus.next_power);
      end else n_pass++;
      n_total++;
      // 6-cycle hold: poff_db rises at edge 6, LOCKOUT at 7, poff_db falls at 12, OFF at 13.
      bus.power_off = 1'b1;
      for (int k = 1; k <= 13; k++) begin
         tick(1);
         if (k == 6) bus.power_off = 1'b0;
         if (k == 6 && bus.next_power !== 1'b1) begin
            $display("FAIL off_before got np=%b exp 1", bus.next_power);
         end else if (k == 6) n_pass++;
         if (k == 7 && bus.next_power !== 1'b0) begin
            $display("FAIL off_latency got np=%b exp 0", bus.next_power);
         end else if (k == 7) n_pass++;
         if (k == 12 && dut.state_q !== StLockout) begin
            $display("FAIL lockout_hold got %0d exp %0d", dut.state_q, StLockout);
         end else if (k == 12) n_pass++;
         if (k == 13 && dut.state_q !== StOff) begin
            $display("FAIL lockout_exit got %0d exp %0d", dut.state_q, StOff);
         end else if (k == 13) n_pass++;
         if (k == 6 || k == 7 || k == 12 || k == 13) n_total++;
      end
   endtask

   // Press edges 1..10: ARMING at 7, pon_db falls at 16, back to OFF at 17.
   task automatic test_short_press();
      bus.power_on = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         tick(1);
         if (k == 10) bus.power_on = 1'b0;
         if (bus.next_power !== 1'b0) begin
            $display("FAIL short_np k=%0d got %b exp 0", k, bus.next_power);
         end else n_pass++;
         n_total++;
         if (k == 16 && dut.state_q !== StArming) begin
            $display("FAIL short_arming got %0d exp %0d", dut.state_q, StArming);
         end else if (k == 16) n_pass++;
         if (k == 17 && dut.state_q !== StOff) begin
            $display("FAIL short_off got %0d exp %0d", dut.state_q, StOff);
         end else if (k == 17) n_pass++;
         if (k == 16 || k == 17) n_total++;
      end
   endtask

   task automatic go_on(input string tag);
      bus.power_on = 1'b1;
      tick(23);
      if (bus.next_power !== 1'b1) begin
         $display("FAIL %s_go_on got np=%b exp 1", tag, bus.next_power);
      end else n_pass++;
      n_total++;
      bus.power_on = 1'b0;
      tick(8);
   endtask

   task automatic test_manual_stall();
      go_on("stall");
      bus.global_state = 2'b01;
      bus.manual_power = 1'b0;
      tick(5);
      if (bus.next_power !== 1'b1) begin
         $display("FAIL stall_semi got np=%b exp 1", bus.next_power);
      end else n_pass++;
      n_total++;
      bus.global_state = 2'b00;
      tick(1);
      if (bus.next_power !== 1'b0 || dut.state_q !== StLockout) begin
         $display("FAIL stall_manual got np=%b state=%0d exp 0 %0d", bus.next_power,
                  dut.state_q, StLockout);
      end else n_pass++;
      n_total++;
      bus.manual_power = 1'b1;
      tick(2);
   endtask

   task automatic test_reserved();
      go_on("rsvd");
      bus.global_state = 2'b11;
      tick(1);
      if (bus.next_power !== 1'b0 || dut.state_q !== StLockout) begin
         $display("FAIL rsvd_on got np=%b state=%0d exp 0 %0d", bus.next_power, dut.state_q,
                  StLockout);
      end else n_pass++;
      n_total++;
      tick(2);
      if (dut.state_q !== StLockout) begin
         $display("FAIL rsvd_hold got %0d exp %0d", dut.state_q, StLockout);
      end else n_pass++;
      n_total++;
      bus.global_state = 2'b00;
      tick(1);
      bus.global_state = 2'b11;
      bus.power_on     = 1'b1;
      tick(12);
      if (dut.state_q !== StOff) begin
         $display("FAIL rsvd_off_frozen got %0d exp %0d", dut.state_q, StOff);
      end else n_pass++;
      n_total++;
      bus.global_state = 2'b00;
      tick(1);
      if (dut.state_q !== StArming || bus.power_light !== 1'b1) begin
         $display("FAIL rsvd_rearm got state=%0d light=%b exp %0d 1", dut.state_q,
                  bus.power_light, StArming);
      end else n_pass++;
      n_total++;
      tick(2);
      #2;
      rst = 1'b0;
      #1;
      if (bus.next_power !== 1'b0 || bus.power_light !== 1'b0 || dut.state_q !== StOff) begin
         $display("FAIL async_reset got np=%b light=%b state=%0d exp 0 0 %0d", bus.next_power,
                  bus.power_light, dut.state_q, StOff);
      end else n_pass++;
      n_total++;
      bus.power_on = 1'b0;
      tick(1);
      rst = 1'b1;
      tick(10);
      if (bus.next_power !== 1'b0 || dut.state_q !== StOff) begin
         $display("FAIL after_reset got np=%b state=%0d exp 0 %0d", bus.next_power, dut.state_q,
                  StOff);
      end else n_pass++;
      n_total++;
   endtask

   task automatic test_idle();
`ifdef POWER_IDLE_TIMEOUT_EN
      bus.power_on = 1'b1;
      tick(23);
      if (bus.next_power !== 1'b1) begin
         $display("FAIL idle_go_on got np=%b exp 1", bus.next_power);
      end else n_pass++;
      n_total++;
      bus.power_on = 1'b0;
      tick(31);
      if (dut.state_q !== StOn) begin
         $display("FAIL idle_31 got %0d exp %0d", dut.state_q, StOn);
      end else n_pass++;
      n_total++;
      tick(1);
      if (dut.state_q !== StLockout || bus.next_power !== 1'b0) begin
         $display("FAIL idle_32 got state=%0d np=%b exp %0d 0", dut.state_q, bus.next_power,
                  StLockout);
      end else n_pass++;
      n_total++;
      tick(10);
      bus.power_on = 1'b1;
      tick(23);
      if (bus.next_power !== 1'b1) begin
         $display("FAIL idle2_go_on got np=%b exp 1", bus.next_power);
      end else n_pass++;
      n_total++;
      bus.power_on = 1'b0;
      tick(19);
      bus.activity = 1'b1;
      tick(1);
      bus.activity = 1'b0;
      tick(31);
      if (dut.state_q !== StOn) begin
         $display("FAIL idle_restart_51 got %0d exp %0d", dut.state_q, StOn);
      end else n_pass++;
      n_total++;
      tick(1);
      if (dut.state_q !== StLockout) begin
         $display("FAIL idle_restart_52 got %0d exp %0d", dut.state_q, StLockout);
      end else n_pass++;
      n_total++;
      tick(10);
`else
      go_on("idle");
      tick(100);
      if (bus.next_power !== 1'b1 || dut.state_q !== StOn) begin
         $display("FAIL no_idle_timeout got np=%b state=%0d exp 1 %0d", bus.next_power,
                  dut.state_q, StOn);
      end else n_pass++;
      n_total++;
      bus.power_off = 1'b1;
      tick(7);
      if (bus.next_power !== 1'b0) begin
         $display("FAIL no_idle_off got np=%b exp 0", bus.next_power);
      end else n_pass++;
      n_total++;
      bus.power_off = 1'b0;
      tick(10);
`endif
   endtask

   initial begin
      n_total          = 0;
      n_pass           = 0;
      rst              = 1'b0;
      bus.global_state = 2'b00;
      bus.power_on     = 1'b0;
      bus.power_off    = 1'b0;
      bus.manual_power = 1'b1;
      bus.activity     = 1'b0;
      test_reset();
      test_long_press();
      test_power_off();
      test_short_press();
      test_manual_stall();
      test_reserved();
      test_idle();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
